// File: rtl/alu_pkg.sv
// Shared types and flag derivation for the add_subs result capture stage.
// Optional per-entry sum parity is enabled by defining ALU_FLAG_PARITY_EN.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef struct packed {
        logic [ALU_W-1:0] result;
        flags_t           flags;
`ifdef ALU_FLAG_PARITY_EN
        logic             parity;
`endif
    } entry_t;

    // C is carry on add and borrow on subtract, so the raw carry-out is
    // inverted in subtract mode.  V compares against the operand that
    // add_subs actually summed (b after mode inversion).
    function automatic flags_t calc_flags(
        input logic [ALU_W-1:0] a,
        input logic [ALU_W-1:0] b,
        input logic             m,
        input logic [ALU_W:0]   sum
    );
        logic [ALU_W-1:0] beff;
        flags_t           f;
        beff = b ^ {ALU_W{m}};
        f.n  = sum[ALU_W-1];
        f.z  = (sum[ALU_W-1:0] == '0);
        f.c  = sum[ALU_W] ^ m;
        f.v  = (a[ALU_W-1] == beff[ALU_W-1])
            && (sum[ALU_W-1] != a[ALU_W-1]);
        return f;
    endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational N/Z/C/V (and optional parity) derivation for one result.
// Ports: a, b, m, sum in; flags (and parity with ALU_FLAG_PARITY_EN) out.
module alu_flag_calc
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             m,
    input  logic [ALU_W:0]   sum,
`ifdef ALU_FLAG_PARITY_EN
    output logic             parity,
`endif
    output flags_t           flags
);

    assign flags = calc_flags(a, b, m, sum);

`ifdef ALU_FLAG_PARITY_EN
    assign parity = ^sum;
`endif

endmodule

// File: rtl/alu_flag_reg.sv
// Capture FIFO for add_subs results with N/Z/C/V flags, valid/ready both sides.
// Ports: clk, rst, in_* push side, out_* pop side, out_count occupancy;
// out_parity exists only when ALU_FLAG_PARITY_EN is defined.
module alu_flag_reg
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_a,
    input  logic [W-1:0]               in_b,
    input  logic                       in_m,
    input  logic [W:0]                 in_sum,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_result,
    output logic [3:0]                 out_flags,
`ifdef ALU_FLAG_PARITY_EN
    output logic                       out_parity,
`endif
    output logic [$clog2(DEPTH):0]     out_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (W != ALU_W || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
    begin : g_bad_cfg
        $error("alu_flag_reg: W must equal ALU_W, DEPTH pow2 >= 2");
    end

    entry_t        mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic          rdy;
    logic          push;
    logic          pop;
    flags_t        new_flags;
    entry_t        new_entry;
    entry_t        head;
`ifdef ALU_FLAG_PARITY_EN
    logic          new_parity;
`endif

    alu_flag_calc u_calc (
        .a      (in_a),
        .b      (in_b),
        .m      (in_m),
        .sum    (in_sum),
`ifdef ALU_FLAG_PARITY_EN
        .parity (new_parity),
`endif
        .flags  (new_flags)
    );

    always_comb begin
        new_entry        = '0;
        new_entry.result = in_sum[W-1:0];
        new_entry.flags  = new_flags;
`ifdef ALU_FLAG_PARITY_EN
        new_entry.parity = new_parity;
`endif
    end

    // in_ready is a register so it never depends on out_ready in the
    // same cycle; it is held low for the whole reset period.
    assign in_ready  = rdy;
    assign out_valid = (count != '0);
    assign push      = in_valid && rdy;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_nx = count;
        unique case (1'b1)
            (push && !pop): count_nx = count + 1'b1;
            (pop && !push): count_nx = count - 1'b1;
            default:        count_nx = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rdy   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= new_entry;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count_nx;
            rdy   <= (count_nx != CW'(DEPTH));
        end
    end

    assign head = mem[rptr];

    always_comb begin
        out_flags         = '0;
        out_flags[FLAG_N] = head.flags.n;
        out_flags[FLAG_Z] = head.flags.z;
        out_flags[FLAG_C] = head.flags.c;
        out_flags[FLAG_V] = head.flags.v;
    end

    assign out_result = head.result;
    assign out_count  = count;

`ifdef ALU_FLAG_PARITY_EN
    assign out_parity = head.parity;
`endif

endmodule

// File: tb/tb_alu_flag_reg.sv
// Scoreboard bench for alu_flag_reg: directed add/sub vectors, backpressure,
// back-to-back push/pop, async reset mid-stream, optional parity.
module tb_alu_flag_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       in_m = 1'b0;
    logic [4:0] in_sum = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_result;
    logic [3:0] out_flags;
    logic [1:0] out_count;
`ifdef ALU_FLAG_PARITY_EN
    logic       out_parity;
`endif

    alu_flag_reg #(.W(4), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_m       (in_m),
        .in_sum     (in_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
`ifdef ALU_FLAG_PARITY_EN
        .out_parity (out_parity),
`endif
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] res;
        logic [3:0] flg;
        logic       par;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       m;
        logic [4:0] s;
        logic [3:0] res;
        logic [3:0] flg;
    } vec_t;

    exp_t sbq[$];
    int   ncmp = 0;
    int   nerr = 0;

    vec_t v1, v2, v3, v4, vpre, vpar;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Holds in_valid until accepted; the expected entry is queued only
    // once the handshake is committed for the coming edge.
    task automatic push(input vec_t v);
        exp_t e;
        bit   ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_m     = v.m;
        in_sum   = v.s;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            e.res = v.res;
            e.flg = v.flg;
            e.par = ^v.s;
            sbq.push_back(e);
        end else begin
            ncmp++;
            nerr++;
            $display("FAIL push_timeout: in_ready stuck at %b, required 1",
                     in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sbq.size() == 0 && out_count == 2'd0) break;
        end
        chk("drain_queue", sbq.size(), 0);
        chk("drain_count", out_count, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL unexpected_out: result %0h with empty queue",
                         out_result);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("out_result", out_result, e.res);
                chk("out_flags", out_flags, e.flg);
`ifdef ALU_FLAG_PARITY_EN
                chk("out_parity", out_parity, e.par);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v1   = '{4'h3, 4'h4, 1'b0, 5'h07, 4'h7, 4'b0000};
        v2   = '{4'h3, 4'h5, 1'b1, 5'h0E, 4'hE, 4'b1010};
        v3   = '{4'h7, 4'h1, 1'b0, 5'h08, 4'h8, 4'b1001};
        v4   = '{4'h8, 4'h8, 1'b0, 5'h10, 4'h0, 4'b0111};
        vpre = '{4'hA, 4'h3, 1'b0, 5'h0D, 4'hD, 4'b1000};
        vpar = '{4'h7, 4'hF, 1'b0, 5'h16, 4'h6, 4'b0010};
        tbl[0] = '{4'h1, 4'h1, 1'b0, 5'h02, 4'h2, 4'b0000};
        tbl[1] = '{4'hF, 4'h1, 1'b0, 5'h10, 4'h0, 4'b0110};
        tbl[2] = '{4'h5, 4'h3, 1'b1, 5'h12, 4'h2, 4'b0000};
        tbl[3] = '{4'h0, 4'h1, 1'b1, 5'h0F, 4'hF, 4'b1010};
        tbl[4] = '{4'h8, 4'h1, 1'b1, 5'h17, 4'h7, 4'b0001};
        tbl[5] = '{4'h6, 4'h6, 1'b0, 5'h0C, 4'hC, 4'b1001};
        tbl[6] = '{4'h4, 4'h4, 1'b1, 5'h10, 4'h0, 4'b0100};
        tbl[7] = '{4'h9, 4'hA, 1'b0, 5'h13, 4'h3, 4'b0011};

        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_count", out_count, 0);
        chk("rst_result", out_result, 0);
        chk("rst_flags", out_flags, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rel_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        chk("rel_ready_high", in_ready, 1);

        out_ready = 1'b1;
        foreach (tbl[i]) begin end
        push(v1);
        chk("lat_valid", out_valid, 1);
        chk("lat_count", out_count, 1);
        @(posedge clk);
        #1;
        chk("pop_count", out_count, 0);
        chk("pop_valid", out_valid, 0);
        push(v2);
        chk("lat_valid", out_valid, 1);
        @(posedge clk);
        #1;
        push(v3);
        chk("lat_valid", out_valid, 1);
        @(posedge clk);
        #1;
        push(v4);
        chk("lat_valid", out_valid, 1);
        @(posedge clk);
        #1;
        push(vpar);
`ifdef ALU_FLAG_PARITY_EN
        chk("parity_16", out_parity, 1);
`endif
        wait_drain();

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push(v1);
        push(v2);
        chk("bp_count", out_count, 2);
        chk("bp_ready", in_ready, 0);
        fork
            push(v3);
            begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("bp_hold_count", out_count, 2);
                    chk("bp_hold_ready", in_ready, 0);
                end
                out_ready = 1'b1;
                @(negedge clk);
                chk("bp_no_pass", in_ready, 0);
                @(posedge clk);
                #1;
                chk("bp_ready_rise", in_ready, 1);
            end
        join
        wait_drain();

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push(vpre);
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) push(tbl[i]);
            end
            begin
                repeat (8) begin
                    @(negedge clk);
                    chk("sim_count", out_count, 1);
                end
            end
        join
        wait_drain();

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push(v1);
        push(v2);
        chk("pre_rst_count", out_count, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", out_count, 0);
        chk("arst_result", out_result, 0);
        chk("arst_flags", out_flags, 0);
        chk("arst_ready", in_ready, 0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("arst_rel_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("arst_ready_up", in_ready, 1);
        out_ready = 1'b1;
        push(v3);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_result", out_result, 8);
        wait_drain();

        chk("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/alu_flag_reg.md
Name: alu_flag_reg

Overview:
- Downstream capture stage for the 4-bit add/subtract unit (add_subs).
- Registers each 5-bit sum together with its operands and mode, derives the N/Z/C/V status flags, and buffers results in a small FIFO.
- Results are presented to the ALU output/writeback logic through a valid/ready handshake, so a stalled consumer never loses an add_subs result.

Parameters:
- W, 4, operand width; sum input is W+1 bits.
- DEPTH, 2, FIFO entries; power of two, min 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept; equals !full, registered-state only (no comb path from out_ready).
- in_a  input  W  operand A as fed to add_subs.
- in_b  input  W  operand B as fed to add_subs (before mode inversion).
- in_m  input  1  mode: 0 = add, 1 = subtract.
- in_sum  input  W+1  add_subs sum; bit W is carry-out.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head.
- out_result  output  W  head result (sum[W-1:0]).
- out_flags  output  4  {N,Z,C,V} of head entry.
- out_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
- Flags are computed combinationally at push and stored with the entry:
  - N = sum[W-1].
  - Z = (sum[W-1:0] == 0).
  - C = sum[W] ^ m; C=1 means carry on add, borrow on subtract.
  - V = (a[W-1] == beff[W-1]) && (sum[W-1] != a[W-1]), with beff = b ^ {W{m}}.
- Latency: an entry pushed in cycle t appears at the outputs in cycle t+1 when the FIFO was empty; otherwise it is queued behind older entries in order.
- Outputs are driven from the FIFO head register array via the read pointer.
- Pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
- Simultaneous push and pop when not full and not empty: both occur and count is unchanged.
- Empty: out_valid=0; out_result/out_flags hold the last read slot contents and are don't-care for checking.
- Full: in_ready=0. A push attempt is ignored, and in_valid may stay high. A pop while full frees a slot; in_ready rises the next cycle (no same-cycle pass-through).
- Reset, asserted at any time including mid-transfer: pointers=0, count=0, out_valid=0, in_ready=0 while rst is high, storage cleared to 0, out_result=0, out_flags=0, out_count=0. In-flight data is discarded. in_ready goes to 1 on the first clk edge after rst deasserts.
- No X propagation: in_a/in_b/in_m/in_sum are sampled only on push.

Optional Feature:
- Macro ALU_FLAG_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = even parity (XOR reduce) of the stored sum[W:0].
  - Stored per entry; resets to 0.
- Undefined: port and storage are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef flags_t (4-bit packed struct N,Z,C,V).
  - typedef entry_t {result, flags[, parity]}.
  - function calc_flags(a,b,m,sum).
- One natural sub-module: alu_flag_calc (combinational flag derivation). It is instantiated once at the push side; this keeps the FIFO pure storage and lets flags be unit-tested alone.

Test Plan:
- Add 0011+0100, m=0, sum=0_0111, single push, out_ready=1 -> next cycle out_valid=1, result 0111, flags N0 Z0 C0 V0; count returns to 0 after pop.
- Subtract 0011-0101, m=1, sum=0_1110 -> result 1110, flags N1 Z0 C1 (borrow) V0.
- Overflow add 0111+0001, sum=0_1000 -> N1 V1 C0; zero case 1000+1000, sum=1_0000 -> Z1 C1 V1.
- Backpressure: out_ready=0, push 3 results with DEPTH=2 -> in_ready=0 after 2nd push, 3rd held. Raise out_ready -> outputs appear in order 1,2,3 with none lost or duplicated.
- Simultaneous push/pop at count=1 for 8 cycles with random operands -> count stays 1 and results match the scoreboard.
- Assert rst mid-stream with count=2 -> out_valid=0, out_count=0, outputs 0 immediately (async). After release, the first new push is the first output. With ALU_FLAG_PARITY_EN defined, sum 1_0110 -> out_parity=1.
